key_mode_ctrl: RTL and testbench



---
 rtl/key_mode_ctrl_pkg.sv | 35 +++
 rtl/key_mode_ctrl_debounce.sv | 104 ++++++++++
 rtl/key_mode_ctrl.sv | 68 ++++++
 tb/tb_key_mode_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_mode_ctrl_pkg.sv
// Shared constants for the push-button mode controller: FSM encodings,
// default timing parameters and the LED on-time table helper.
package key_mode_ctrl_pkg;

    localparam int unsigned CLK_HZ = 50_000_000;

    localparam int CNT_W  = 26;
    localparam int ON_W   = 23;
    localparam int MODE_W = 2;

    typedef logic [MODE_W-1:0] mode_t;

    localparam int unsigned DEF_T_DEBOUNCE = 1_000_000;
    localparam int unsigned DEF_T_LONG     = 50_000_000;
    localparam int unsigned DEF_T_PERIOD   = 5_000_000;

    localparam logic [1:0] ST_IDLE         = 2'd0;
    localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
    localparam logic [1:0] ST_HELD         = 2'd2;
    localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

    // Quarter steps of the blink period; mode 3 turns the LED off.
    function automatic logic [ON_W-1:0] on_time_of(input mode_t mode, input int unsigned period);
        logic [31:0] v;
        v = '0;
        case (mode)
            2'd0: v = period / 4;
            2'd1: v = period / 2;
            2'd2: v = (3 * period) / 4;
            2'd3: v = '0;
        endcase
        return v[ON_W-1:0];
    endfunction

endpackage

// File: rtl/key_mode_ctrl_debounce.sv
// Synchronises and debounces an active-low key, emitting one pulse per
// accepted press and one pulse when a press has been held long enough.
module key_mode_ctrl_debounce
    import key_mode_ctrl_pkg::*;
#(
    parameter int unsigned T_DEBOUNCE = DEF_T_DEBOUNCE,
    parameter int unsigned T_LONG     = DEF_T_LONG
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_in,
    output logic key_pulse,
    output logic long_pulse
);

    localparam logic [CNT_W-1:0] DEB_MAX  = CNT_W'(T_DEBOUNCE - 1);
    localparam logic [CNT_W-1:0] LONG_MAX = CNT_W'(T_LONG - 1);

    logic [1:0]       sync_q;
    logic             key_s;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             long_done_q, long_done_d;
    logic             key_pulse_q, key_pulse_d;
    logic             long_pulse_q, long_pulse_d;

    assign key_s = sync_q[1];

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        long_done_d  = long_done_q;
        key_pulse_d  = 1'b0;
        long_pulse_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                long_done_d = 1'b0;
                cnt_d       = '0;
                if (!key_s) begin
                    state_d = ST_PRESS_WAIT;
                end
            end
            ST_PRESS_WAIT: begin
                if (key_s) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_MAX) begin
                    state_d     = ST_HELD;
                    cnt_d       = '0;
                    key_pulse_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_HELD: begin
                // Counter parks at LONG_MAX; long_done keeps a re-bounced press from firing twice.
                if (key_s) begin
                    state_d = ST_RELEASE_WAIT;
                    cnt_d   = '0;
                end else if (cnt_q == LONG_MAX) begin
                    if (!long_done_q) begin
                        long_pulse_d = 1'b1;
                        long_done_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RELEASE_WAIT: begin
                if (!key_s) begin
                    state_d = ST_HELD;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_MAX) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q       <= 2'b11;
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            long_done_q  <= 1'b0;
            key_pulse_q  <= 1'b0;
            long_pulse_q <= 1'b0;
        end else begin
            sync_q       <= {sync_q[0], key_in};
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            long_done_q  <= long_done_d;
            key_pulse_q  <= key_pulse_d;
            long_pulse_q <= long_pulse_d;
        end
    end

    assign key_pulse  = key_pulse_q;
    assign long_pulse = long_pulse_q;

endmodule

// File: rtl/key_mode_ctrl.sv
// Button-driven blink mode selector: short presses step the mode, a long
// press returns to mode 0; ON_TIME follows the mode.
module key_mode_ctrl
    import key_mode_ctrl_pkg::*;
#(
    parameter int unsigned T_DEBOUNCE = DEF_T_DEBOUNCE,
    parameter int unsigned T_LONG     = DEF_T_LONG,
    parameter int unsigned T_PERIOD   = DEF_T_PERIOD
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              KEY_IN,
    output logic              KEY_PULSE,
    output logic              LONG_PULSE,
    output logic [MODE_W-1:0] MODE,
    output logic [ON_W-1:0]   ON_TIME
);

    localparam logic [ON_W-1:0] ON_RST = on_time_of(2'd0, T_PERIOD);

    logic            key_pulse;
    logic            long_pulse;
    mode_t           mode_q, mode_d;
    logic [ON_W-1:0] on_time_q, on_time_d;
    logic [ON_W-1:0] on_tab [4];

    key_mode_ctrl_debounce #(
        .T_DEBOUNCE (T_DEBOUNCE),
        .T_LONG     (T_LONG)
    ) u_debounce (
        .clk        (CLK),
        .rst_n      (RST_N),
        .key_in     (KEY_IN),
        .key_pulse  (key_pulse),
        .long_pulse (long_pulse)
    );

    for (genvar gi = 0; gi < 4; gi++) begin : g_tab
        assign on_tab[gi] = on_time_of(2'(gi), T_PERIOD);
    end

    // Long press wins should both pulses ever coincide.
    always_comb begin
        mode_d = mode_q;
        if (long_pulse) begin
            mode_d = '0;
        end else if (key_pulse) begin
            mode_d = mode_q + 2'd1;
        end
        on_time_d = on_tab[mode_d];
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            mode_q    <= '0;
            on_time_q <= ON_RST;
        end else begin
            mode_q    <= mode_d;
            on_time_q <= on_time_d;
        end
    end

    assign KEY_PULSE  = key_pulse;
    assign LONG_PULSE = long_pulse;
    assign MODE       = mode_q;
    assign ON_TIME    = on_time_q;

endmodule

// File: tb/tb_key_mode_ctrl.sv
// Self-checking bench for key_mode_ctrl with short timing parameters; a
// run-length reference model predicts pulses, MODE and ON_TIME every cycle.
module tb_key_mode_ctrl;

    localparam int TD = 10;
    localparam int TL = 50;
    localparam int TP = 100;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        KEY_IN = 1'b1;
    logic        KEY_PULSE;
    logic        LONG_PULSE;
    logic [1:0]  MODE;
    logic [22:0] ON_TIME;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic        m_s1, m_s2;
    bit          m_pressed;
    int          m_run;
    int          m_hold;
    bit          m_long_done;
    logic        exp_kp, exp_lp;
    logic [1:0]  exp_mode;
    logic [22:0] exp_on;

    // Per-segment statistics
    int seg_kp, seg_lp, seg_first_kp, seg_first_lp;

    key_mode_ctrl #(
        .T_DEBOUNCE (TD),
        .T_LONG     (TL),
        .T_PERIOD   (TP)
    ) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .KEY_IN     (KEY_IN),
        .KEY_PULSE  (KEY_PULSE),
        .LONG_PULSE (LONG_PULSE),
        .MODE       (MODE),
        .ON_TIME    (ON_TIME)
    );

    always #5 CLK = ~CLK;

    function automatic logic [22:0] ref_on(input logic [1:0] m);
        case (m)
            2'd0: return 23'(TP / 4);
            2'd1: return 23'(TP / 2);
            2'd2: return 23'((3 * TP) / 4);
            default: return 23'd0;
        endcase
    endfunction

    function void model_reset();
        m_s1 = 1'b1;
        m_s2 = 1'b1;
        m_pressed = 0;
        m_run = 0;
        m_hold = 0;
        m_long_done = 0;
        exp_kp = 1'b0;
        exp_lp = 1'b0;
        exp_mode = 2'd0;
        exp_on = ref_on(2'd0);
    endfunction

    // A press is accepted after TD+1 consecutive low synchronised samples and
    // released after TD+1 consecutive high ones; a long press is TL low samples
    // counted from acceptance (or from the last release bounce).
    function void model_update(input logic pin);
        logic ks;
        logic kp, lp;
        ks = m_s2;
        m_s2 = m_s1;
        m_s1 = pin;
        if (exp_lp) exp_mode = 2'd0;
        else if (exp_kp) exp_mode = exp_mode + 2'd1;
        exp_on = ref_on(exp_mode);
        kp = 1'b0;
        lp = 1'b0;
        if (!m_pressed) begin
            if (ks == 1'b0) m_run++;
            else m_run = 0;
            if (m_run == TD + 1) begin
                m_pressed = 1;
                kp = 1'b1;
                m_run = 0;
                m_hold = 0;
                m_long_done = 0;
            end
        end else if (ks) begin
            m_run++;
            if (m_run == TD + 1) begin
                m_pressed = 0;
                m_run = 0;
            end
        end else if (m_run > 0) begin
            m_run = 0;
            m_hold = 0;
        end else begin
            m_hold++;
            if (m_hold == TL && !m_long_done) begin
                lp = 1'b1;
                m_long_done = 1;
            end
        end
        exp_kp = kp;
        exp_lp = lp;
    endfunction

    // Drives KEY_IN at level k for n cycles, comparing every cycle with the model.
    task automatic drive_seg(input logic k, input int n);
        seg_kp = 0;
        seg_lp = 0;
        seg_first_kp = -1;
        seg_first_lp = -1;
        for (int i = 1; i <= n; i++) begin
            KEY_IN = k;
            @(posedge CLK);
            model_update(k);
            @(negedge CLK);
            n_checks++;
            if ({KEY_PULSE, LONG_PULSE, MODE, ON_TIME} !== {exp_kp, exp_lp, exp_mode, exp_on}) begin
                n_errors++;
                $display("FAIL cycle_model t=%0t got kp=%b lp=%b mode=%0d on=%0d expected kp=%b lp=%b mode=%0d on=%0d",
                         $time, KEY_PULSE, LONG_PULSE, MODE, ON_TIME, exp_kp, exp_lp, exp_mode, exp_on);
            end
            if (KEY_PULSE === 1'b1) begin
                seg_kp++;
                if (seg_first_kp < 0) seg_first_kp = i;
            end
            if (LONG_PULSE === 1'b1) begin
                seg_lp++;
                if (seg_first_lp < 0) seg_first_lp = i;
            end
        end
        $display("seg key=%0d len=%0d key_pulses=%0d long_pulses=%0d mode=%0d on_time=%0d",
                 k, n, seg_kp, seg_lp, MODE, ON_TIME);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST_N = 1'b0;
        KEY_IN = 1'b1;
        model_reset();
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({KEY_PULSE, LONG_PULSE, MODE, ON_TIME} !== {1'b0, 1'b0, 2'd0, 23'd25}) begin
            n_errors++;
            $display("FAIL reset_values got kp=%b lp=%b mode=%0d on=%0d expected 0 0 0 25",
                     KEY_PULSE, LONG_PULSE, MODE, ON_TIME);
        end
    endtask

    task automatic test_single_press();
        drive_seg(1'b0, 20);
        n_checks++;
        if (seg_kp != 1 || seg_first_kp != 13) begin
            n_errors++;
            $display("FAIL single_press got pulses=%0d at=%0d expected 1 at 13", seg_kp, seg_first_kp);
        end
        n_checks++;
        if (MODE !== 2'd1 || ON_TIME !== 23'd50) begin
            n_errors++;
            $display("FAIL single_mode got mode=%0d on=%0d expected 1 50", MODE, ON_TIME);
        end
        drive_seg(1'b1, 20);
    endtask

    task automatic test_bounce();
        int total;
        int first_at;
        drive_seg(1'b0, 5);
        total = seg_kp;
        drive_seg(1'b1, 3);
        total += seg_kp;
        drive_seg(1'b0, 15);
        total += seg_kp;
        first_at = seg_first_kp;
        n_checks++;
        if (total != 1 || first_at != 13) begin
            n_errors++;
            $display("FAIL press_bounce got pulses=%0d at=%0d expected 1 at 13", total, first_at);
        end
        drive_seg(1'b1, 20);
    endtask

    task automatic test_short_presses();
        logic [1:0]  mode_tab [4];
        logic [22:0] on_tab [4];
        mode_tab = '{2'd1, 2'd2, 2'd3, 2'd0};
        on_tab   = '{23'd50, 23'd75, 23'd0, 23'd25};
        do_reset();
        for (int p = 0; p < 4; p++) begin
            drive_seg(1'b0, 15);
            n_checks++;
            if (seg_kp != 1 || MODE !== mode_tab[p] || ON_TIME !== on_tab[p]) begin
                n_errors++;
                $display("FAIL short_press%0d got pulses=%0d mode=%0d on=%0d expected 1 %0d %0d",
                         p, seg_kp, MODE, ON_TIME, mode_tab[p], on_tab[p]);
            end
            drive_seg(1'b1, 20);
        end
    endtask

    task automatic test_long_press();
        drive_seg(1'b0, 80);
        n_checks++;
        if (seg_kp != 1 || seg_lp != 1 || seg_first_lp - seg_first_kp != 50) begin
            n_errors++;
            $display("FAIL long_press got kp=%0d lp=%0d gap=%0d expected 1 1 50",
                     seg_kp, seg_lp, seg_first_lp - seg_first_kp);
        end
        n_checks++;
        if (MODE !== 2'd0 || ON_TIME !== 23'd25) begin
            n_errors++;
            $display("FAIL long_mode got mode=%0d on=%0d expected 0 25", MODE, ON_TIME);
        end
        drive_seg(1'b1, 20);
    endtask

    task automatic test_release_bounce();
        logic k_seq [9];
        int   n_seq [9];
        int   kp_seq [9];
        k_seq  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        n_seq  = '{15, 4, 10, 8, 15, 12, 15, 20, 1};
        kp_seq = '{1, 0, 0, 0, 0, 0, 1, 0, 0};
        for (int s = 0; s < 9; s++) begin
            drive_seg(k_seq[s], n_seq[s]);
            n_checks++;
            if (seg_kp != kp_seq[s]) begin
                n_errors++;
                $display("FAIL release_bounce seg%0d got pulses=%0d expected %0d", s, seg_kp, kp_seq[s]);
            end
        end
    endtask

    task automatic test_random();
        logic k;
        int len;
        k = 1'b0;
        for (int s = 0; s < 60; s++) begin
            len = ($urandom_range(0, 7) == 0) ? $urandom_range(40, 70) : $urandom_range(1, 25);
            drive_seg(k, len);
            k = ~k;
        end
        drive_seg(1'b1, 20);
    endtask

    task automatic test_reset_mid_held();
        int lat;
        do_reset();
        drive_seg(1'b0, 20);
        #2;
        RST_N = 1'b0;
        #1;
        n_checks++;
        if ({KEY_PULSE, LONG_PULSE, MODE, ON_TIME} !== {1'b0, 1'b0, 2'd0, 23'd25}) begin
            n_errors++;
            $display("FAIL async_reset got kp=%b lp=%b mode=%0d on=%0d expected 0 0 0 25",
                     KEY_PULSE, LONG_PULSE, MODE, ON_TIME);
        end
        model_reset();
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        drive_seg(1'b0, 30);
        lat = seg_first_kp;
        n_checks++;
        if (seg_kp != 1 || lat != 13) begin
            n_errors++;
            $display("FAIL reset_held_press got pulses=%0d at=%0d expected 1 at 13", seg_kp, lat);
        end
        drive_seg(1'b1, 20);
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_press();
        test_bounce();
        test_short_presses();
        test_long_press();
        test_release_bounce();
        test_random();
        test_reset_mid_held();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
